// File: rtl/scratchmem_arb_fta.sv
// Round-robin arbiter sharing the scratchmem FTA 128-bit request port, with an in-order tag queue for ack return.
// Optional build macro: SCRATCHARB_PRI0_EN (port 0 wins whenever valid).
package fta_bus_pkg;
    localparam logic [2:0] CLASSIC = 3'd0;
    localparam logic [2:0] ERC     = 3'd7;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [2:0]   cti;
        logic [3:0]   pri;
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [15:0]  sel;
        logic [31:0]  adr;
        logic [31:0]  padr;
        logic [127:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         stall;
        logic         err;
        logic         rty;
        logic [3:0]   pri;
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;
endpackage

module scratchmem_arb_fta
    import fta_bus_pkg::*;
#(
    parameter int NPORT  = 3,
    parameter int QDEPTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  fta_cmd_request128_t  [NPORT-1:0] req_i,
    output fta_cmd_response128_t [NPORT-1:0] resp_o,
    output fta_cmd_request128_t              mreq_o,
    input  fta_cmd_response128_t             mresp_i,
    output logic [$clog2(QDEPTH):0]          outstanding_o,
    output logic                             orphan_o
);
    localparam int PW = $clog2(NPORT);
    localparam int QW = $clog2(QDEPTH);

    logic [NPORT-1:0]     valid;
    logic                 gnt_v;
    logic [PW-1:0]        gnt_idx;
    logic                 push, pop, full, empty, can_grant;
    int                   idx;

    logic [PW-1:0]        rr_q;
    logic [QW-1:0]        wp_q, rp_q;
    logic [QW:0]          cnt_q, cnt_d;
    logic [PW-1:0]        tq_q [QDEPTH];
    fta_cmd_request128_t  mreq_q;
    fta_cmd_response128_t rsp_q;
    logic [NPORT-1:0]     ack_q;
    logic                 orphan_q;

    always_comb begin
        for (int n = 0; n < NPORT; n++) begin
            valid[n] = req_i[n].cyc & req_i[n].stb;
        end
    end

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (QW+1)'(QDEPTH));
    assign pop       = mresp_i.ack & ~empty;
    assign can_grant = ~full | pop;

    // Search starts one past the last winner so every port gets a turn.
    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 1; i <= NPORT; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!gnt_v && valid[idx]) begin
                gnt_v   = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
`ifdef SCRATCHARB_PRI0_EN
        if (valid[0]) begin
            gnt_v   = 1'b1;
            gnt_idx = '0;
        end
`endif
        if (!can_grant) gnt_v = 1'b0;
    end

    // Non-ERC writes are posted: the RAM never acks them, so they take no tag.
    assign push = gnt_v && (!req_i[gnt_idx].we || req_i[gnt_idx].cti == ERC);

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q     <= PW'(NPORT-1);
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            mreq_q   <= '0;
            rsp_q    <= '0;
            ack_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wp_q <= wp_q + 1'b1;
`ifdef SCRATCHARB_PRI0_EN
            if (gnt_v && gnt_idx != '0) rr_q <= gnt_idx;
`else
            if (gnt_v) rr_q <= gnt_idx;
`endif
            if (gnt_v) begin
                mreq_q <= req_i[gnt_idx];
            end else begin
                mreq_q.cyc <= 1'b0;
                mreq_q.stb <= 1'b0;
                mreq_q.we  <= 1'b0;
            end
            ack_q <= '0;
            if (pop) begin
                ack_q[tq_q[rp_q]] <= 1'b1;
                rsp_q             <= mresp_i;
                rp_q              <= rp_q + 1'b1;
            end
            if (mresp_i.ack && empty) orphan_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) tq_q[wp_q] <= gnt_idx;
    end

    // Response payload is shared; only ack is steered to the tag-queue head.
    always_comb begin
        for (int n = 0; n < NPORT; n++) begin
            resp_o[n]       = rsp_q;
            resp_o[n].ack   = ack_q[n];
            resp_o[n].stall = valid[n] && !(gnt_v && gnt_idx == PW'(n));
        end
    end

    assign mreq_o        = mreq_q;
    assign outstanding_o = cnt_q;
    assign orphan_o      = orphan_q;
endmodule

// File: tb/tb_scratchmem_arb_fta.sv
// Bench for scratchmem_arb_fta: scratchmem model with variable ack latency, scoreboard of expected acks.
module tb_scratchmem_arb_fta;
    import fta_bus_pkg::*;

    localparam int NP = 3;

    logic clk = 1'b0;
    logic rst;
    fta_cmd_request128_t  [NP-1:0] req;
    fta_cmd_response128_t [NP-1:0] resp;
    fta_cmd_request128_t           mreq;
    fta_cmd_response128_t          mresp;
    logic [2:0]                    outstanding;
    logic                          orphan;

    scratchmem_arb_fta #(.NPORT(NP), .QDEPTH(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .resp_o(resp), .mreq_o(mreq),
        .mresp_i(mresp), .outstanding_o(outstanding), .orphan_o(orphan)
    );

    always #5 clk = ~clk;

    typedef struct { int port; logic [7:0] tid; logic [31:0] adr; } exp_t;
    typedef struct { int due; logic [7:0] tid; logic [31:0] adr; } pend_t;

    exp_t  sb[$];
    pend_t pend[$];
    int    iss_cyc[$], ack_cyc[$];
    int    n_tests = 0, n_fail = 0;
    int    cyc = 0, lat = 1, nack = 0, max_out = 0;
    bit    force_ack = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic fta_cmd_request128_t mk_req(input logic we, input logic [2:0] cti,
                                                   input logic [7:0] tid, input logic [31:0] padr);
        fta_cmd_request128_t r;
        r      = '0;
        r.cyc  = 1'b1;
        r.stb  = 1'b1;
        r.we   = we;
        r.cti  = cti;
        r.tid  = tid;
        r.padr = padr;
        r.adr  = padr;
        r.sel  = '1;
        r.dat  = {4{padr}};
        r.pri  = 4'd3;
        r.cid  = tid[3:0];
        return r;
    endfunction

    task automatic push_exp(input int p, input logic [7:0] tid, input logic [31:0] adr);
        exp_t e;
        e.port = p; e.tid = tid; e.adr = adr;
        sb.push_back(e);
    endtask

    // Presents n requests back to back, holding each until it is no longer stalled.
    task automatic drive_port(input int p, input int n, input logic [7:0] tid0, input logic we,
                              input logic [2:0] cti, input logic [31:0] adr0);
        for (int k = 0; k < n; k++) begin
            int w;
            w = 0;
            req[p] = mk_req(we, cti, tid0 + 8'(k), adr0 + 32'(k * 16));
            @(negedge clk);
            while (resp[p].stall && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) chk("grant_timeout", 128'(p), 128'hFF);
            @(posedge clk); #1;
        end
        req[p] = '0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || pend.size() != 0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        #1;
        chk("drain_sb_empty", 128'(sb.size()), 128'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scratchmem model: acks reads and ERC writes in issue order after lat cycles.
    initial mresp = '0;
    always begin
        pend_t pe;
        @(posedge clk); #1;
        mresp = '0;
        if (force_ack) begin
            mresp.ack = 1'b1;
            mresp.tid = 8'hEE;
            mresp.dat = {16{8'hEE}};
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            pe = pend.pop_front();
            mresp.ack = 1'b1;
            mresp.tid = pe.tid;
            mresp.adr = pe.adr;
            mresp.dat = {16{pe.tid}};
            ack_cyc.push_back(cyc);
        end
        if (mreq.cyc && mreq.stb) begin
            iss_cyc.push_back(cyc);
            if (!mreq.we || mreq.cti == ERC) begin
                pe.due = cyc + lat; pe.tid = mreq.tid; pe.adr = mreq.padr;
                pend.push_back(pe);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (int'(outstanding) > max_out) max_out = int'(outstanding);
        for (int p = 0; p < NP; p++) begin
            if (resp[p].ack) begin
                nack++;
                if (sb.size() == 0) begin
                    chk("unexpected_ack_port", 128'(p), 128'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 128'(p), 128'(e.port));
                    chk("ack_tid", 128'(resp[p].tid), 128'(e.tid));
                    chk("ack_adr", 128'(resp[p].adr), 128'(e.adr));
                    chk("ack_dat", resp[p].dat, {16{e.tid}});
                    chk("dat_bcast", resp[(p + 1) % NP].dat, {16{e.tid}});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1;
        req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mreq", 128'(mreq), 128'd0);
        chk("rst_outstanding", 128'(outstanding), 128'd0);
        chk("rst_orphan", 128'(orphan), 128'd0);
        for (int p = 0; p < NP; p++) begin
            chk("rst_ack", 128'(resp[p].ack), 128'd0);
            chk("rst_dat", resp[p].dat, 128'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read, port 1.
        @(posedge clk); #1;
        push_exp(1, 8'h10, 32'h100);
        req[1] = mk_req(1'b0, CLASSIC, 8'h10, 32'h100);
        @(negedge clk);
        chk("t2_stall", 128'(resp[1].stall), 128'd0);
        chk("t2_out_n", 128'(outstanding), 128'd0);
        @(posedge clk); #1;
        req[1] = '0;
        @(negedge clk);
        chk("t2_mreq_cyc", 128'(mreq.cyc), 128'd1);
        chk("t2_mreq_padr", 128'(mreq.padr), 128'h100);
        chk("t2_out_n1", 128'(outstanding), 128'd1);
        @(negedge clk);
        chk("t2_out_n2", 128'(outstanding), 128'd1);
        @(negedge clk); #1;
        chk("t2_out_n3", 128'(outstanding), 128'd0);
        chk("t2_nack", 128'(nack), 128'd1);
        drain();

        // All three ports reading continuously.
        iss_cyc.delete();
`ifdef SCRATCHARB_PRI0_EN
        for (int k = 0; k < 3; k++) push_exp(0, 8'h20 + 8'(k), 32'h1000 + 32'(k * 16));
        for (int k = 0; k < 3; k++) begin
            push_exp(2, 8'h40 + 8'(k), 32'h1200 + 32'(k * 16));
            push_exp(1, 8'h30 + 8'(k), 32'h1100 + 32'(k * 16));
        end
`else
        for (int k = 0; k < 3; k++) begin
            push_exp(2, 8'h40 + 8'(k), 32'h1200 + 32'(k * 16));
            push_exp(0, 8'h20 + 8'(k), 32'h1000 + 32'(k * 16));
            push_exp(1, 8'h30 + 8'(k), 32'h1100 + 32'(k * 16));
        end
`endif
        @(posedge clk); #1;
        fork
            drive_port(0, 3, 8'h20, 1'b0, CLASSIC, 32'h1000);
            drive_port(1, 3, 8'h30, 1'b0, CLASSIC, 32'h1100);
            drive_port(2, 3, 8'h40, 1'b0, CLASSIC, 32'h1200);
        join
        drain();
        chk("t3_issues", 128'(iss_cyc.size()), 128'd9);
        if (iss_cyc.size() == 9) chk("t3_no_idle", 128'(iss_cyc[8] - iss_cyc[0]), 128'd8);

        // ERC write acks; plain write is issued but not acked.
        push_exp(0, 8'h50, 32'h300);
        @(posedge clk); #1;
        drive_port(0, 1, 8'h50, 1'b1, ERC, 32'h300);
        drain();
        max_out = 0;
        iss_cyc.delete();
        n0 = nack;
        push_exp(2, 8'h52, 32'h400);
        @(posedge clk); #1;
        drive_port(2, 1, 8'h51, 1'b1, CLASSIC, 32'h400);
        drive_port(2, 1, 8'h52, 1'b0, CLASSIC, 32'h400);
        drain();
        repeat (3) @(negedge clk);
        #1;
        chk("t4_max_out", 128'(max_out), 128'd1);
        chk("t4_issues", 128'(iss_cyc.size()), 128'd2);
        chk("t4_acks", 128'(nack - n0), 128'd1);

        // Queue full with slow acks.
        lat = 20;
        iss_cyc.delete();
        ack_cyc.delete();
`ifdef SCRATCHARB_PRI0_EN
        for (int k = 0; k < 3; k++) push_exp(0, 8'h60 + 8'(k), 32'h2000 + 32'(k * 16));
        for (int k = 0; k < 3; k++) push_exp(1, 8'h70 + 8'(k), 32'h2100 + 32'(k * 16));
`else
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 8'h60 + 8'(k), 32'h2000 + 32'(k * 16));
            push_exp(1, 8'h70 + 8'(k), 32'h2100 + 32'(k * 16));
        end
`endif
        @(posedge clk); #1;
        fork
            drive_port(0, 3, 8'h60, 1'b0, CLASSIC, 32'h2000);
            drive_port(1, 3, 8'h70, 1'b0, CLASSIC, 32'h2100);
            begin
                repeat (10) @(negedge clk);
`ifdef SCRATCHARB_PRI0_EN
                chk("t5_stall0", 128'(resp[0].stall), 128'd0);
`else
                chk("t5_stall0", 128'(resp[0].stall), 128'd1);
`endif
                chk("t5_stall1", 128'(resp[1].stall), 128'd1);
                chk("t5_out_full", 128'(outstanding), 128'd4);
                chk("t5_mreq_idle", 128'(mreq.cyc), 128'd0);
            end
        join
        drain();
        chk("t5_issues", 128'(iss_cyc.size()), 128'd6);
        if (iss_cyc.size() == 6 && ack_cyc.size() > 0) begin
            chk("t5_first4_b2b", 128'(iss_cyc[3] - iss_cyc[0]), 128'd3);
            chk("t5_unblock", 128'(iss_cyc[4]), 128'(ack_cyc[0] + 1));
        end
        lat = 1;

        // Orphan ack with an empty queue.
        n0 = nack;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_orphan", 128'(orphan), 128'd1);
        chk("t6_no_ack", 128'(nack - n0), 128'd0);
        chk("t6_out", 128'(outstanding), 128'd0);
        repeat (10) @(negedge clk);
        chk("t6_orphan_held", 128'(orphan), 128'd1);

        // Reset with three reads in flight.
        lat = 20;
        n0 = nack;
        @(posedge clk); #1;
        drive_port(1, 3, 8'h90, 1'b0, CLASSIC, 32'h3000);
        @(posedge clk); #1;
        chk("t7_out_before", 128'(outstanding), 128'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t7_out_after", 128'(outstanding), 128'd0);
        chk("t7_orphan_clr", 128'(orphan), 128'd0);
        chk("t7_mreq_cyc", 128'(mreq.cyc), 128'd0);
        drain();
        repeat (3) @(negedge clk);
        #1;
        chk("t7_orphan", 128'(orphan), 128'd1);
        chk("t7_no_ack", 128'(nack - n0), 128'd0);
        lat = 1;

        // After reset port 0 wins first.
        push_exp(0, 8'hA0, 32'h4000);
        push_exp(1, 8'hB0, 32'h4100);
        @(posedge clk); #1;
        fork
            drive_port(1, 1, 8'hB0, 1'b0, CLASSIC, 32'h4100);
            drive_port(0, 1, 8'hA0, 1'b0, CLASSIC, 32'h4000);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/scratchmem_arb_fta.md
# scratchmem_arb_fta

Round-robin arbiter that shares the single FTA 128-bit request port of the PCI scratchpad RAM among several bus masters (CPU instruction fetch, CPU data, DMA). It accepts at most one request per clock, forwards it registered to the scratchmem, and records which port expects an acknowledge. Because the RAM returns acks in issue order, it routes each returning response back to the originating port through an in-order tag queue.

## Interface
Parameters:
- NPORT, 3: number of requesting ports; legal range 2..8.
- QDEPTH, 16: tag-queue depth; power of two, at least 4. It must cover the scratchmem issue-to-ack latency to sustain one request per cycle.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  fta_cmd_request128_t[NPORT]  per-port requests; a port is valid when cyc&stb.
- resp_o  out  fta_cmd_response128_t[NPORT]  per-port responses. stall doubles as the request back-pressure signal.
- mreq_o  out  fta_cmd_request128_t  request to the scratchmem.
- mresp_i  in  fta_cmd_response128_t  response from the scratchmem.
- outstanding_o  out  $clog2(QDEPTH)+1  count of acks still expected.
- orphan_o  out  1  sticky flag: an ack arrived while the queue was empty.

## Operation
Arbitration:
- Each cycle, the valid ports are searched starting at rr_ptr+1, wrapping modulo NPORT. The first valid port found is granted.
- rr_ptr is loaded with the granted index only when a grant occurs.
- No grant occurs when the queue is full and no pop happens this cycle.

Stall:
- resp_o[n].stall is combinational. It is 1 when port n is valid and not granted this cycle.
- A requester must hold its request unchanged while stall=1.
- A granted request is consumed in that cycle. The port must drop the request or present the next one.

Issue:
- The granted request is copied field-for-field into mreq_o on the next edge.
- When there is no grant, mreq_o.cyc=0, stb=0 and we=0; all other fields hold.

Ack expectation:
- A request expects an ack if it is a read (we=0), or a write with cti==fta_bus_pkg::ERC.
- Non-ERC writes are issued but are neither queued nor acked.

Tag queue:
- A FIFO of port indices, QDEPTH entries.
- Push the granted index when the request expects an ack. Pop on mresp_i.ack.
- Push and pop in the same cycle are allowed, including when the queue is full.
- outstanding_o always equals the queue occupancy.

Return path:
- On mresp_i.ack, resp_o[head] receives ack, dat, tid, cid, adr, err, rty and pri from mresp_i, registered one cycle.
- All other ports get ack=0. dat is broadcast to every port.

Orphan acks:
- An ack that arrives with the queue empty is dropped and sets orphan_o.
- orphan_o clears only on reset.

## Timing
- Reset values: mreq_o all zero (cyc=0); resp_o[*].ack=0; resp_o[*].dat=0; rr_ptr=NPORT-1, so port 0 wins first; queue empty; outstanding_o=0; orphan_o=0.
- Request valid and granted at cycle N → mreq_o.cyc=1 at N+1. Back-to-back grants give one issue per cycle.
- mresp_i.ack at cycle M → resp_o[p].ack=1 at M+1, for exactly one cycle per mresp_i ack.
- Full queue with no pop: all valid ports stall and mreq_o.cyc=0 the next cycle.
- Full queue with a pop in the same cycle: a grant proceeds.
- Reset mid-operation:
  - The queue, rr_ptr and mreq_o are cleared the same edge.
  - Requests already inside the scratchmem pipeline still ack afterwards. These appear as orphans and set orphan_o; this is accepted behaviour.
- The queue pointers are $clog2(QDEPTH) bits and wrap naturally.
- The occupancy counter saturates at neither end; it is protected by the full/empty gating.

## Configuration
- SCRATCHARB_PRI0_EN defined:
  - Port 0 wins whenever it is valid, regardless of rr_ptr.
  - The remaining ports round-robin among themselves.
  - rr_ptr updates only on grants to ports 1..NPORT-1.
- Not defined: pure round-robin across all ports as described above.

## Test plan
- Single read, port 1, padr=0x100 after reset → mreq_o.cyc at N+1; the ack routes to resp_o[1] only; outstanding_o returns 0→1→0.
- Ports 0, 1 and 2 all request continuously, reads only → grants cycle 0,1,2,0,1,2 with no idle cycles. With SCRATCHARB_PRI0_EN the grants are all port 0 until port 0 drops.
- Non-ERC write from port 2 followed by a read from port 2 → outstanding_o peaks at 1; exactly one ack reaches port 2, carrying the read data.
- QDEPTH=4 with the scratchmem ack delayed 20 cycles → after 4 reads every valid port stalls; the first ack unblocks exactly one grant in the same cycle.
- Forced mresp_i.ack with the queue empty → no resp_o ack; orphan_o=1, held until rst_i.
- rst_i asserted for one cycle with 3 reads in flight → outstanding_o=0 after the edge; the 3 late acks are dropped; orphan_o=1.
